pp_bus_packer_1to8: RTL and testbench

- Inverse of the 8:1 partial-product slice selector: serially accepts eight 9-bit words and packs them into one 73-bit bus.
- Word k lands in bits [9k+8:9k]; bit 72 is zero.
- Sits between the radix-4 Booth partial-product generator stage and any stage that consumes the packed partial-product bus.
- Double-buffered: a collect buffer fills while the previous packed frame waits in the output register.

---
 rtl/pp_bus_packer_1to8.sv | 50 +++++
 tb/tb_pp_bus_packer_1to8.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pp_bus_packer_1to8.sv
// pp_bus_packer_1to8: serially collects NUM_WORDS partial-product words and packs them into one bus,
// double-buffered so a new frame fills while the previous one waits downstream.
module pp_bus_packer_1to8 #(
  parameter int WORD_W = 9,
  parameter int NUM_WORDS = 8,
  parameter int BUS_W = 73,
  localparam int CNT_W = $clog2(NUM_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic [WORD_W-1:0] data_in_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [BUS_W-1:0]  data_out_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CNT_W-1:0]  slot_o
);
  localparam int PACK_W = WORD_W * NUM_WORDS;
  logic [NUM_WORDS-1:0][WORD_W-1:0] coll_q, merged;
  logic [PACK_W-1:0] out_q;
  logic [CNT_W-1:0] slot_q;
  logic last, acc, xfer, done;
  // the top word bypasses the collect buffer so the frame loads on the edge that accepts it
  always_comb begin
    last = slot_q == CNT_W'(NUM_WORDS - 1);
    ready_o = ~clear_i & (~last | ~valid_o | ready_i);
    acc = valid_i & ready_o;
    xfer = valid_o & ready_i;
    done = acc & last;
    merged = coll_q;
    merged[NUM_WORDS-1] = data_in_i;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      coll_q <= '0;
      out_q <= '0;
      valid_o <= 1'b0;
      slot_q <= '0;
    end else begin
      if (acc) coll_q[slot_q] <= data_in_i;
      slot_q <= clear_i ? '0 : slot_q + CNT_W'(acc);
      if (done) out_q <= merged;
      valid_o <= done | (valid_o & ~xfer);
    end
  end
  assign data_out_o = BUS_W'(out_q);
  assign slot_o = slot_q;
endmodule

// File: tb/tb_pp_bus_packer_1to8.sv
// tb_pp_bus_packer_1to8: directed vector table, async-reset sequences and a random scoreboard run.
module tb_pp_bus_packer_1to8;
  logic clk = 0, rst_n_i = 0, clear_i = 0, valid_i = 0, ready_i = 0;
  logic [8:0] data_in_i = 0;
  logic ready_o, valid_o;
  logic [72:0] data_out_o;
  logic [2:0] slot_o;
  always #5 clk = ~clk;
  pp_bus_packer_1to8 dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .clear_i(clear_i), .data_in_i(data_in_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_out_o(data_out_o), .valid_o(valid_o),
    .ready_i(ready_i), .slot_o(slot_o)
  );
  typedef struct {
    logic v, c, r;
    logic [8:0] d;
    logic er, ev;
    logic [2:0] es;
    logic chk;
    logic [72:0] ed;
  } vec_t;
  vec_t tbl[$];
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [72:0] packw(input int base, input int step);
    logic [72:0] r = '0;
    for (int k = 0; k < 8; k++) r[9*k +: 9] = 9'(base + k * step);
    return r;
  endfunction
  task automatic add(input logic v, c, r, input logic [8:0] d, input logic er, ev,
                     input logic [2:0] es, input logic ck = 0, input logic [72:0] ed = '0);
    vec_t t;
    t = '{v, c, r, d, er, ev, es, ck, ed};
    tbl.push_back(t);
  endtask
  task automatic apply(input vec_t t);
    @(negedge clk);
    valid_i = t.v; clear_i = t.c; ready_i = t.r; data_in_i = t.d;
    #1;
    chk("ready", 73'(ready_o), 73'(t.er));
    chk("valid", 73'(valid_o), 73'(t.ev));
    chk("slot", 73'(slot_o), 73'(t.es));
    if (t.chk) chk("data", data_out_o, t.ed);
  endtask
  task automatic send(input int base, input int step);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      valid_i = 1; data_in_i = 9'(base + k * step);
    end
    @(negedge clk);
    valid_i = 0;
    #1;
  endtask
  logic [71:0] exp_q[$];
  logic [71:0] m_cur;
  logic [2:0] m_slot;
  logic m_vld, m_rdy, v, c, r, acc;
  logic [8:0] d;
  int sent, got, cyc;
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 73'(valid_o), 73'(0));
    chk("rst_slot", 73'(slot_o), 73'(0));
    chk("rst_data", data_out_o, 73'(0));
    chk("rst_ready", 73'(ready_o), 73'(1));
    @(negedge clk) rst_n_i = 1;
    for (int i = 0; i < 8; i++) add(1, 0, 1, 9'(i + 1), 1, 0, 3'(i));
    add(0, 0, 1, 0, 1, 1, 0, 1, packw(1, 1));
    add(0, 0, 1, 0, 1, 0, 0, 1, packw(1, 1));
    for (int i = 0; i < 8; i++) add(1, 0, 0, 9'h1FF, 1, 0, 3'(i));
    for (int i = 0; i < 7; i++) add(1, 0, 0, 9'h0AA, 1, 1, 3'(i));
    add(1, 0, 0, 9'h0AA, 0, 1, 7, 1, packw(9'h1FF, 0));
    add(1, 0, 0, 9'h0AA, 0, 1, 7, 1, packw(9'h1FF, 0));
    add(1, 0, 1, 9'h0AA, 1, 1, 7, 1, packw(9'h1FF, 0));
    add(0, 0, 0, 0, 1, 1, 0, 1, packw(9'h0AA, 0));
    add(0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, packw(9'h0AA, 0));
    for (int i = 0; i < 5; i++) add(1, 0, 0, 9'(9'h011 + i), 1, 0, 3'(i));
    add(1, 1, 0, 9'h1EE, 0, 0, 5);
    for (int i = 0; i < 8; i++) add(1, 0, 0, 9'(9'h100 + i), 1, 0, 3'(i));
    add(0, 0, 1, 0, 1, 1, 0, 1, packw(9'h100, 1));
    add(0, 0, 0, 0, 1, 0, 0, 1, packw(9'h100, 1));
    for (int i = 0; i < 24; i++)
      add(1, 0, 1, 9'(i * 3 + 5), 1, i >= 8 && i % 8 == 0, 3'(i % 8), i >= 8 && i % 8 == 0, packw((i - 8) * 3 + 5, 3));
    add(0, 0, 1, 0, 1, 1, 0, 1, packw(16 * 3 + 5, 3));
    foreach (tbl[i]) apply(tbl[i]);
    @(negedge clk);
    valid_i = 0; clear_i = 0; ready_i = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      valid_i = 1; data_in_i = 9'(k);
    end
    @(negedge clk);
    valid_i = 0;
    #1 chk("mid_slot", 73'(slot_o), 73'(4));
    #2 rst_n_i = 0;
    #1 chk("async_slot", 73'(slot_o), 73'(0));
    @(negedge clk) rst_n_i = 1;
    send(9'h0C0, 1);
    chk("full_valid", 73'(valid_o), 73'(1));
    chk("full_data", data_out_o, packw(9'h0C0, 1));
    #2 rst_n_i = 0;
    #1;
    chk("async_valid", 73'(valid_o), 73'(0));
    chk("async_data", data_out_o, 73'(0));
    @(negedge clk) rst_n_i = 1;
    ready_i = 1;
    send(9'h050, 7);
    chk("post_rst_valid", 73'(valid_o), 73'(1));
    chk("post_rst_data", data_out_o, packw(9'h050, 7));
    @(negedge clk) rst_n_i = 0;
    @(negedge clk) rst_n_i = 1;
    m_cur = '0; m_slot = 0; m_vld = 0; sent = 0; got = 0; cyc = 0;
    while (got < 100 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      v = sent < 100 && $urandom_range(0, 3) != 0;
      c = $urandom_range(0, 63) == 0;
      r = 1'($urandom_range(0, 1));
      d = 9'($urandom);
      valid_i = v; clear_i = c; ready_i = r; data_in_i = d;
      #1;
      m_rdy = ~c & (m_slot != 7 | ~m_vld | r);
      chk("rnd_ready", 73'(ready_o), 73'(m_rdy));
      chk("rnd_valid", 73'(valid_o), 73'(m_vld));
      chk("rnd_slot", 73'(slot_o), 73'(m_slot));
      chk("rnd_bit72", 73'(data_out_o[72]), 73'(0));
      if (m_vld && r) begin
        chk("rnd_frame", data_out_o, {1'b0, exp_q.pop_front()});
        got++;
      end
      acc = v & m_rdy;
      if (acc) m_cur[9*m_slot +: 9] = d;
      if (acc && m_slot == 7) begin
        exp_q.push_back(m_cur);
        sent++;
        m_vld = 1;
      end else if (m_vld && r) m_vld = 0;
      m_slot = c ? 3'd0 : m_slot + 3'(acc);
    end
    chk("rnd_frames", 73'(got), 73'(100));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
